// File: rtl/uart_timer_pkg.sv
// Shared types and helpers for the UART bit-period timer.
package uart_timer_pkg;

    localparam int DEF_DIV_W = 16;
    localparam int DEF_BIT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    // Half-length first period for mid-bit sampling; never shorter than one clock.
    function automatic logic [31:0] half_period(input logic [31:0] d);
        logic [31:0] h;
        h = d >> 1;
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Generic modulo counter: counts 0..term, reloads to 0 after the terminal value.
module mod_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         hit
);

    assign hit = (count == term);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr || load) begin
            count <= '0;
        end else if (en) begin
            count <= hit ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/uart_bit_timer.sv
// Bit-period tick source and bit index for UART TX/RX control FSMs.
module uart_bit_timer
    import uart_timer_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int BIT_W = DEF_BIT_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] divisor,
    input  logic [BIT_W-1:0] frame_len,
    input  logic             cont_mode,
    input  logic             half_start,
    output logic             busy,
    output logic             bit_tick,
    output logic [BIT_W-1:0] bit_idx,
    output logic             frame_done,
    output logic             err
);

    timer_state_t     state, state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] len_q;
    logic             cont_q;
    logic             half_pending;

    logic             legal;
    logic             can_start;
    logic             accept;
    logic             clr_cnt;
    logic [DIV_W-1:0] pre_term;
    logic [BIT_W-1:0] bit_term;
    logic             pre_hit;
    logic             idx_last;
    logic [DIV_W-1:0] prescale_count_unused;

    assign busy       = (state == RUN);
    assign bit_tick   = busy & pre_hit;
    assign frame_done = bit_tick & idx_last;
    assign bit_term   = len_q - BIT_W'(1);

    // A one-shot frame's final tick doubles as a restart window.
    always_comb begin
        legal     = (divisor != '0) && (frame_len != '0);
        can_start = (state == IDLE) || (frame_done && !cont_q);
        accept    = start && !abort && legal && can_start;

        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = RUN;
        end else if ((state == RUN) && frame_done && !cont_q) begin
            state_nxt = IDLE;
        end

        clr_cnt = (state_nxt == IDLE);

        if (half_pending) begin
            pre_term = DIV_W'(half_period(32'(div_q))) - DIV_W'(1);
        end else begin
            pre_term = div_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            div_q        <= '0;
            len_q        <= '0;
            cont_q       <= 1'b0;
            half_pending <= 1'b0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                div_q        <= divisor;
                len_q        <= frame_len;
                cont_q       <= cont_mode;
                half_pending <= half_start;
            end else if (abort || bit_tick) begin
                half_pending <= 1'b0;
            end

            if (abort) begin
                err <= 1'b0;
            end else if (start && !accept) begin
                err <= 1'b1;
            end
        end
    end

    // The prescaler value itself is only needed inside the counter.
    mod_counter #(.W(DIV_W)) u_prescaler (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (clr_cnt),
        .load  (accept),
        .en    (busy),
        .term  (pre_term),
        .count (prescale_count_unused),
        .hit   (pre_hit)
    );

    mod_counter #(.W(BIT_W)) u_bit_counter (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (clr_cnt),
        .load  (accept),
        .en    (bit_tick),
        .term  (bit_term),
        .count (bit_idx),
        .hit   (idx_last)
    );

endmodule

// File: tb/tb_uart_bit_timer.sv
// Self-checking bench for uart_bit_timer against a countdown-style reference model.
module tb_uart_bit_timer;

    localparam int DIV_W = 16;
    localparam int BIT_W = 4;

    logic             clk = 1'b0;
    logic             nrst;
    logic             start;
    logic             abort;
    logic [DIV_W-1:0] divisor;
    logic [BIT_W-1:0] frame_len;
    logic             cont_mode;
    logic             half_start;
    logic             busy;
    logic             bit_tick;
    logic [BIT_W-1:0] bit_idx;
    logic             frame_done;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Reference model: run flag, cycles left in current period, bit position.
    bit m_run;
    bit m_err;
    bit m_cont;
    int m_idx;
    int m_len;
    int m_div;
    int m_left;

    int          cyc;
    logic [31:0] tickMask;
    logic [31:0] doneMask;

    uart_bit_timer #(.DIV_W(DIV_W), .BIT_W(BIT_W)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .divisor    (divisor),
        .frame_len  (frame_len),
        .cont_mode  (cont_mode),
        .half_start (half_start),
        .busy       (busy),
        .bit_tick   (bit_tick),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit modelTick();
        return m_run && (m_left == 1);
    endfunction

    function automatic bit modelDone();
        return modelTick() && (m_idx == m_len - 1);
    endfunction

    task automatic modelReset();
        m_run  = 1'b0;
        m_err  = 1'b0;
        m_cont = 1'b0;
        m_idx  = 0;
        m_len  = 0;
        m_div  = 0;
        m_left = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit tick;
        bit done;
        bit canStart;
        tick = modelTick();
        done = modelDone();
        if (abort) begin
            m_run = 1'b0;
            m_idx = 0;
            m_err = 1'b0;
        end else begin
            canStart = !m_run || (done && !m_cont);
            if (start && divisor != 0 && frame_len != 0 && canStart) begin
                m_run  = 1'b1;
                m_div  = int'(divisor);
                m_len  = int'(frame_len);
                m_cont = cont_mode;
                m_idx  = 0;
                m_left = half_start ? ((m_div / 2 < 1) ? 1 : m_div / 2) : m_div;
            end else begin
                if (start) m_err = 1'b1;
                if (m_run) begin
                    if (tick) begin
                        m_left = m_div;
                        if (done) begin
                            m_idx = 0;
                            if (!m_cont) m_run = 1'b0;
                        end else begin
                            m_idx++;
                        end
                    end else begin
                        m_left--;
                    end
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("busy",       32'(busy),       32'(m_run));
        checkOutput("bit_tick",   32'(bit_tick),   32'(modelTick()));
        checkOutput("bit_idx",    32'(bit_idx),    32'(m_run ? m_idx : 0));
        checkOutput("frame_done", 32'(frame_done), 32'(modelDone()));
        checkOutput("err",        32'(err),        32'(m_err));
    endtask

    // Drive one cycle of inputs at a falling edge, then check the following cycle.
    task automatic applyStimulus(input bit st, input bit ab, input int dv, input int fl,
                                 input bit cm, input bit hs);
        start      = st;
        abort      = ab;
        divisor    = DIV_W'(dv);
        frame_len  = BIT_W'(fl);
        cont_mode  = cm;
        half_start = hs;
        modelStep();
        @(negedge clk);
        checkAll();
        cyc++;
        if (cyc < 32) begin
            if (bit_tick)   tickMask = tickMask | (32'd1 << cyc);
            if (frame_done) doneMask = doneMask | (32'd1 << cyc);
        end
    endtask

    // Idle cycles with random configuration noise that must not disturb a frame.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 9)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic markStart();
        cyc      = 0;
        tickMask = '0;
        doneMask = '0;
    endtask

    initial begin
        nrst       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        divisor    = '0;
        frame_len  = '0;
        cont_mode  = 1'b0;
        half_start = 1'b0;
        modelReset();
        markStart();

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy),       32'd0);
        checkOutput("rst_tick", 32'(bit_tick),   32'd0);
        checkOutput("rst_idx",  32'(bit_idx),    32'd0);
        checkOutput("rst_done", 32'(frame_done), 32'd0);
        checkOutput("rst_err",  32'(err),        32'd0);
        nrst = 1'b1;

        // Basic one-shot: ticks in cycles 4, 8, 12; done in 12.
        markStart();
        applyStimulus(1'b1, 1'b0, 4, 3, 1'b0, 1'b0);
        idleCycles(12);
        checkOutput("basic_ticks", tickMask, 32'h0000_1110);
        checkOutput("basic_done",  doneMask, 32'h0000_1000);
        checkOutput("basic_busy13", 32'(busy), 32'd0);

        // Half start, D=5: ticks in 2 and 7.
        markStart();
        applyStimulus(1'b1, 1'b0, 5, 2, 1'b0, 1'b1);
        idleCycles(8);
        checkOutput("half5_ticks", tickMask, 32'h0000_0084);
        checkOutput("half5_done",  doneMask, 32'h0000_0080);

        // Half start, D=1: ticks in 1 and 2.
        markStart();
        applyStimulus(1'b1, 1'b0, 1, 2, 1'b0, 1'b1);
        idleCycles(3);
        checkOutput("half1_ticks", tickMask, 32'h0000_0006);
        checkOutput("half1_done",  doneMask, 32'h0000_0004);

        // Continuous, D=2, L=2, half start: ticks 1,3,5,7,9; done 3,7.
        markStart();
        applyStimulus(1'b1, 1'b0, 2, 2, 1'b1, 1'b1);
        idleCycles(8);
        checkOutput("cont_ticks", tickMask, 32'h0000_02AA);
        checkOutput("cont_done",  doneMask, 32'h0000_0088);
        checkOutput("cont_busy",  32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

        // Illegal divisor sets err without starting.
        applyStimulus(1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
        checkOutput("div0_err",  32'(err),  32'd1);
        checkOutput("div0_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        checkOutput("idle_abort_err", 32'(err), 32'd0);

        // Start during RUN: err set, timing unchanged.
        markStart();
        applyStimulus(1'b1, 1'b0, 4, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2, 5, 1'b0, 1'b0);
        checkOutput("overlap_err", 32'(err), 32'd1);
        idleCycles(11);
        checkOutput("overlap_ticks", tickMask, 32'h0000_1110);
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

        // Start coincident with one-shot frame_done: back-to-back restart.
        markStart();
        applyStimulus(1'b1, 1'b0, 3, 1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("b2b_first_done", doneMask, 32'h0000_0008);
        markStart();
        applyStimulus(1'b1, 1'b0, 2, 2, 1'b0, 1'b0);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_err",  32'(err),  32'd0);
        idleCycles(4);
        checkOutput("b2b_ticks", tickMask, 32'h0000_0014);
        checkOutput("b2b_done",  doneMask, 32'h0000_0010);

        // Abort in cycle 5 of D=4, L=3 after an overlapping start set err.
        markStart();
        applyStimulus(1'b1, 1'b0, 4, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4, 3, 1'b0, 1'b0);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 7, 7, 1'b0, 1'b0);
        checkOutput("abort_busy",  32'(busy),    32'd0);
        checkOutput("abort_idx",   32'(bit_idx), 32'd0);
        checkOutput("abort_err",   32'(err),     32'd0);
        checkOutput("abort_ticks", tickMask,     32'h0000_0010);
        checkOutput("abort_done",  doneMask,     32'h0000_0000);
        idleCycles(2);

        // Asynchronous reset mid-frame.
        applyStimulus(1'b1, 1'b0, 3, 4, 1'b1, 1'b0);
        idleCycles(5);
        start = 1'b0;
        abort = 1'b0;
        #2 nrst = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy),       32'd0);
        checkOutput("arst_tick", 32'(bit_tick),   32'd0);
        checkOutput("arst_idx",  32'(bit_idx),    32'd0);
        checkOutput("arst_done", 32'(frame_done), 32'd0);
        checkOutput("arst_err",  32'(err),        32'd0);
        modelReset();
        @(negedge clk);
        nrst = 1'b1;
        checkAll();

        // Longest frame at one clock per bit.
        markStart();
        applyStimulus(1'b1, 1'b0, 1, 15, 1'b0, 1'b0);
        idleCycles(15);
        checkOutput("max_ticks", tickMask, 32'h0000_FFFE);
        checkOutput("max_done",  doneMask, 32'h0000_8000);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 49) == 0),
                          int'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
